// File: rtl/mac_tx_frame_build.sv
// Ethernet II frame builder: prepends the 14-byte header (dst MAC, src MAC,
// EtherType) to a payload stream and realigns the payload by two bytes across
// 64-bit words on its way to the 10G MAC transmit AXI-Stream.
module mac_tx_frame_build #(
  parameter int MIN_IFG_CYCLES = 1
) (
  input  logic        tx_axis_aclk,
  input  logic        tx_axis_areset,
  input  logic [63:0] frame_tx_axis_tdata,
  input  logic [7:0]  frame_tx_axis_tkeep,
  input  logic        frame_tx_axis_tvalid,
  input  logic        frame_tx_axis_tlast,
  output logic        frame_tx_axis_tready,
  input  logic [15:0] protocol_type,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  output logic [63:0] mac_tx_axis_tdata,
  output logic [7:0]  mac_tx_axis_tkeep,
  output logic        mac_tx_axis_tvalid,
  output logic        mac_tx_axis_tlast,
  input  logic        mac_tx_axis_tready,
  output logic        rcv_stream_end
);

  localparam int IFG_W = (MIN_IFG_CYCLES > 0) ? $clog2(MIN_IFG_CYCLES + 1) : 1;
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(MIN_IFG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_BODY, S_TAIL, S_DONE
  } state_t;

  state_t           r_state;
  logic [IFG_W-1:0] r_ifg_cnt;
  logic [47:0]      r_dst;
  logic [47:0]      r_src;
  logic [15:0]      r_type;
  logic [47:0]      r_res_data;   // payload bytes 2-7 of the previous beat
  logic [5:0]       r_res_keep;

  logic        w_ld;
  logic        w_short;
  logic [47:0] w_dst_wire;
  logic [47:0] w_src_wire;
  logic [63:0] w_word0;
  logic [63:0] w_word1;
  logic [63:0] w_body;

  // MAC addresses are stored MSB-first on the wire; AXI byte 0 is tdata[7:0].
  function automatic logic [47:0] wire_order(input logic [47:0] v);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[8*i +: 8] = v[47-8*i -: 8];
    return r;
  endfunction

  assign w_ld       = ~mac_tx_axis_tvalid | mac_tx_axis_tready;
  // Contiguous keep: at most two valid bytes exactly when byte 2 is unused.
  assign w_short    = ~frame_tx_axis_tkeep[2];
  assign w_dst_wire = wire_order(r_dst);
  assign w_src_wire = wire_order(r_src);
  assign w_word0    = {w_src_wire[15:0], w_dst_wire};
  assign w_word1    = {frame_tx_axis_tdata[15:0], r_type[7:0], r_type[15:8], w_src_wire[47:16]};
  assign w_body     = {frame_tx_axis_tdata[15:0], r_res_data};

  // Payload is only pulled while a header/body word can be loaded into the output stage.
  assign frame_tx_axis_tready = w_ld & ((r_state == S_HDR1) | (r_state == S_BODY));

  // Frame completes on the cycle the MAC accepts the tlast beat.
  assign rcv_stream_end = (r_state == S_DONE) & mac_tx_axis_tvalid &
                          mac_tx_axis_tready & mac_tx_axis_tlast;

  // Frame sequencing FSM together with the single-register output stage.
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_areset) begin
    if (!tx_axis_areset) begin
      r_state            <= S_IDLE;
      r_ifg_cnt          <= '0;
      r_dst              <= '0;
      r_src              <= '0;
      r_type             <= '0;
      r_res_data         <= '0;
      r_res_keep         <= '0;
      mac_tx_axis_tdata  <= '0;
      mac_tx_axis_tkeep  <= '0;
      mac_tx_axis_tvalid <= 1'b0;
      mac_tx_axis_tlast  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ld) mac_tx_axis_tvalid <= 1'b0;
          if (r_ifg_cnt != '0) begin
            r_ifg_cnt <= r_ifg_cnt - 1'b1;
          end else if (frame_tx_axis_tvalid) begin
            r_dst   <= dst_mac;
            r_src   <= src_mac;
            r_type  <= protocol_type;
            r_state <= S_HDR0;
          end
        end
        S_HDR0: begin
          if (w_ld) begin
            mac_tx_axis_tdata  <= w_word0;
            mac_tx_axis_tkeep  <= 8'hFF;
            mac_tx_axis_tlast  <= 1'b0;
            mac_tx_axis_tvalid <= 1'b1;
            r_state            <= S_HDR1;
          end
        end
        S_HDR1, S_BODY: begin
          if (w_ld) begin
            if (frame_tx_axis_tvalid) begin
              mac_tx_axis_tdata  <= (r_state == S_HDR1) ? w_word1 : w_body;
              mac_tx_axis_tvalid <= 1'b1;
              r_res_data         <= frame_tx_axis_tdata[63:16];
              r_res_keep         <= frame_tx_axis_tkeep[7:2];
              if (frame_tx_axis_tlast && w_short) begin
                // Last payload bytes fit in this word: it closes the frame.
                mac_tx_axis_tkeep <= (r_state == S_HDR1) ?
                                     {frame_tx_axis_tkeep[1:0], 6'h3F} :
                                     {frame_tx_axis_tkeep[1:0], r_res_keep};
                mac_tx_axis_tlast <= 1'b1;
                r_state           <= S_DONE;
              end else begin
                mac_tx_axis_tkeep <= 8'hFF;
                mac_tx_axis_tlast <= 1'b0;
                r_state           <= frame_tx_axis_tlast ? S_TAIL : S_BODY;
              end
            end else begin
              // Payload bubble: drain the output stage and wait.
              mac_tx_axis_tvalid <= 1'b0;
            end
          end
        end
        S_TAIL: begin
          if (w_ld) begin
            mac_tx_axis_tdata  <= {16'h0000, r_res_data};
            mac_tx_axis_tkeep  <= {2'b00, r_res_keep};
            mac_tx_axis_tlast  <= 1'b1;
            mac_tx_axis_tvalid <= 1'b1;
            r_state            <= S_DONE;
          end
        end
        S_DONE: begin
          if (mac_tx_axis_tvalid && mac_tx_axis_tready && mac_tx_axis_tlast) begin
            mac_tx_axis_tvalid <= 1'b0;
            mac_tx_axis_tlast  <= 1'b0;
            r_ifg_cnt          <= IFG_LOAD;
            r_state            <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_frame_build.sv
// Randomized bench for mac_tx_frame_build: every frame is modelled as a flat
// byte list (header + payload) chopped into 8-byte beats and compared beat by
// beat with what the MAC side accepts.
module tb_mac_tx_frame_build;
  localparam int IFG = 1;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] f_tdata = '0;
  logic [7:0]  f_tkeep = '0;
  logic        f_tvalid = 1'b0;
  logic        f_tlast = 1'b0;
  logic        f_tready;
  logic [15:0] ptype = '0;
  logic [47:0] dmac = '0;
  logic [47:0] smac = '0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        stream_end;

  always #5 clk = ~clk;

  mac_tx_frame_build #(.MIN_IFG_CYCLES(IFG)) dut (
    .tx_axis_aclk        (clk),
    .tx_axis_areset      (rst_n),
    .frame_tx_axis_tdata (f_tdata),
    .frame_tx_axis_tkeep (f_tkeep),
    .frame_tx_axis_tvalid(f_tvalid),
    .frame_tx_axis_tlast (f_tlast),
    .frame_tx_axis_tready(f_tready),
    .protocol_type       (ptype),
    .dst_mac             (dmac),
    .src_mac             (smac),
    .mac_tx_axis_tdata   (m_tdata),
    .mac_tx_axis_tkeep   (m_tkeep),
    .mac_tx_axis_tvalid  (m_tvalid),
    .mac_tx_axis_tlast   (m_tlast),
    .mac_tx_axis_tready  (m_tready),
    .rcv_stream_end      (stream_end)
  );

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  int frames_exp = 0;
  int frames_done = 0;
  int stall_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: header bytes in wire order followed by payload, cut into 8-byte beats.
  task automatic model_push(input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t, input byte_q_t pl);
    byte_q_t fb;
    for (int i = 0; i < 6; i++) fb.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(s[47-8*i -: 8]);
    fb.push_back(t[15:8]);
    fb.push_back(t[7:0]);
    foreach (pl[i]) fb.push_back(pl[i]);
    for (int b = 0; b < fb.size(); b += 8) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < 8; j++) begin
        if (b + j < fb.size()) begin
          e.data[8*j +: 8] = fb[b+j];
          e.keep[j] = 1'b1;
        end
      end
      e.last = (b + 8 >= fb.size());
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({pfx, "_tdata"}, m_tdata, 64'd0);
    check({pfx, "_tkeep"}, 64'(m_tkeep), 64'd0);
    check({pfx, "_tlast"}, 64'(m_tlast), 64'd0);
    check({pfx, "_end"}, 64'(stream_end), 64'd0);
    check({pfx, "_in_rdy"}, 64'(f_tready), 64'd0);
  endtask

  // Drives one payload frame; optional MAC stall after beat stall_beat, reset after beat abort_beat.
  task automatic send_frame(input int nbytes, input logic [15:0] t, input int stall_beat,
                            input int abort_beat, input bit gaps);
    byte_q_t pl;
    logic [47:0] d;
    logic [47:0] s;
    int nbeats;
    bit acc;
    d = 48'({$urandom(), $urandom()});
    s = 48'({$urandom(), $urandom()});
    dmac = d;
    smac = s;
    ptype = t;
    for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom()));
    model_push(d, s, t, pl);
    if (abort_beat < 0) frames_exp++;
    nbeats = (nbytes + 7) / 8;
    for (int bi = 0; bi < nbeats; bi++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          f_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      f_tdata = {$urandom(), $urandom()};
      f_tkeep = '0;
      for (int j = 0; j < 8; j++) begin
        if (bi * 8 + j < nbytes) begin
          f_tdata[8*j +: 8] = pl[bi*8+j];
          f_tkeep[j] = 1'b1;
        end
      end
      f_tlast = (bi == nbeats - 1);
      f_tvalid = 1'b1;
      acc = 1'b0;
      for (int w = 0; w < 300 && !acc; w++) begin
        @(negedge clk);
        acc = f_tready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check("in_timeout", 64'd0, 64'd1);
        f_tvalid = 1'b0;
        return;
      end
      // Header inputs may wander once the frame is under way.
      dmac = 48'({$urandom(), $urandom()});
      smac = 48'({$urandom(), $urandom()});
      ptype = ~t;
      if (bi == stall_beat) stall_cnt = 5;
      if (bi == abort_beat) begin
        f_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        return;
      end
    end
    f_tvalid = 1'b0;
    f_tlast = 1'b0;
  endtask

  task automatic wait_frames();
    int w;
    w = 0;
    while ((frames_done != frames_exp || exp_q.size() != 0) && w < 3000) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (w >= 3000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // MAC ready: forced low for stall windows, otherwise always-ready or random.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stall_cnt > 0) begin
        m_tready = 1'b0;
        stall_cnt--;
      end else begin
        m_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;
  bit          prev_stall = 1'b0;
  bit          in_frame = 1'b0;
  bit          have_end = 1'b0;
  int          cyc = 0;
  int          t_end = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      in_frame = 1'b0;
      have_end = 1'b0;
    end else begin
      cyc++;
      if (prev_stall) begin
        check("hold_valid", 64'(m_tvalid), 64'd1);
        check("hold_data", m_tdata, prev_data);
        check("hold_keep", 64'(m_tkeep), 64'(prev_keep));
        check("hold_last", 64'(m_tlast), 64'(prev_last));
      end
      if (m_tvalid && !m_tready) check("in_rdy_stall", 64'(f_tready), 64'd0);
      if (stream_end || (m_tvalid && m_tready && m_tlast))
        check("end_pulse", 64'(stream_end), 64'(m_tvalid & m_tready & m_tlast));
      if (m_tvalid && !in_frame) begin
        in_frame = 1'b1;
        if (have_end) check("ifg_gap", 64'(cyc - t_end - 1 >= IFG), 64'd1);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          logic [63:0] mask;
          e = exp_q.pop_front();
          mask = '0;
          for (int j = 0; j < 8; j++) if (e.keep[j]) mask[8*j +: 8] = 8'hFF;
          check("beat_data", m_tdata & mask, e.data);
          check("beat_keep", 64'(m_tkeep), 64'(e.keep));
          check("beat_last", 64'(m_tlast), 64'(e.last));
          $display("beat data=%h keep=%h last=%0d", m_tdata, m_tkeep, m_tlast);
        end
        if (m_tlast) begin
          in_frame = 1'b0;
          have_end = 1'b1;
          t_end = cyc;
        end
      end
      if (stream_end) frames_done++;
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_keep = m_tkeep;
      prev_last = m_tlast;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(28, 16'h0806, -1, -1, 1'b0);
    wait_frames();
    send_frame(8, 16'h0800, -1, -1, 1'b0);
    wait_frames();
    send_frame(10, 16'h0800, -1, -1, 1'b0);
    wait_frames();
    send_frame(40, 16'h0800, 1, -1, 1'b0);
    wait_frames();
    send_frame(20, 16'h0800, -1, -1, 1'b0);
    send_frame(30, 16'h0806, -1, -1, 1'b0);
    wait_frames();
    send_frame(64, 16'h0800, -1, 3, 1'b0);
    send_frame(24, 16'h0806, -1, -1, 1'b0);
    wait_frames();
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      send_frame(int'($urandom_range(1, 80)), ($urandom_range(0, 1) != 0) ? 16'h0806 : 16'h0800,
                 -1, -1, 1'b1);
      if ($urandom_range(0, 1) != 0) wait_frames();
    end
    wait_frames();
    check("exp_drained", 64'(exp_q.size()), 64'd0);
    check("frame_count", 64'(frames_done), 64'(frames_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
